rx_frontend_dc_cal: RTL and testbench
=====================================

# rx_frontend_dc_cal

Calibration sequencer for the RX frontend's DC-offset correction. On `start` it zeroes the frontend's I/Q DC-offset registers over the settings bus, waits for the frontend pipeline to flush, and averages 2^`log2_len` valid frontend output samples per channel. It then writes the negated mean back as the new offsets. It sits beside `rx_frontend` and owns that block's DC-offset settings writes during calibration.

## Interface
- `BASE`, 0: settings-bus base address of the frontend.
- `OFF_I`, 0: register offset of I DC-offset register.
- `OFF_Q`, 1: register offset of Q DC-offset register.
- `SETTLE_CYC`, 16: clk cycles waited after the clear writes before accumulating (≥1).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin calibration; sampled only in IDLE.
- `abort`  in  1  cancel calibration; return to IDLE.
- `log2_len`  in  4  average length = 2^`log2_len` (0 → 1 sample); latched at `start`.
- `sample_i`, `sample_q`  in  16  signed frontend output samples.
- `sample_vld`  in  1  sample qualifier.
- `set_stb`  out  1  settings write strobe, one cycle per write.
- `set_addr`  out  8  `BASE+OFF_I` or `BASE+OFF_Q`.
- `set_data`  out  32  {1'b1 load, 7'b0, offset[23:0]}.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `dc_i`, `dc_q`  out  16  last computed signed means; held until the next completion.

## Operation
- FSM: IDLE → CLR_I → CLR_Q → SETTLE → ACCUM → DIVIDE → WR_I → WR_Q → DONE → IDLE.
- In CLR_I and CLR_Q, the block writes offset 0 with `set_data`=0x80000000.
- SETTLE counts `SETTLE_CYC` cycles.
- ACCUM clears the 32-bit signed accumulators on entry. Each cycle with `sample_vld`=1, it adds sign-extended samples and increments the count. ACCUM exits on the cycle the 2^`log2_len`-th valid sample is taken. Cycles with `sample_vld`=0 are not counted.
- DIVIDE computes mean = acc >>> `log2_len` (arithmetic shift, truncation toward −∞) and latches `dc_i`/`dc_q`.
- The offset is −mean, saturated to 16 bits (−(−32768) → 32767), sign-extended and shifted left 8 into 24 bits.
- `abort` in any non-IDLE state: next state is IDLE and no further `set_stb` is issued. A write already strobed stays. `done` is not pulsed. `dc_*` are unchanged.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `abort` wins.
- `rst_n` low at any time: immediate return to IDLE. All outputs 0, accumulators and counters 0.

## Timing
- `start` accepted in cycle 0 gives:
  - `set_stb` (clear I) in cycle 1.
  - `set_stb` (clear Q) in cycle 2.
  - SETTLE in cycles 3..2+`SETTLE_CYC`.
- After the last valid sample is accepted in cycle T:
  - DIVIDE in T+1.
  - WR_I `set_stb` in T+2.
  - WR_Q `set_stb` in T+3.
  - `done`=1 in T+4.
  - `busy`=0 from T+5.
- `busy` goes high the cycle after `start` and low the cycle after DONE or abort.
- `set_addr`/`set_data` are 0 whenever `set_stb`=0.
- All outputs are registered.

## Configuration
- `RX_DC_CAL_Q_EN` defined: both channels are calibrated as above.
- Undefined: Q accumulator absent. CLR_Q and WR_Q states are skipped, so `done` comes one cycle earlier in each phase. `dc_q` is tied to 0.

## Structure
- Package `rx_dc_cal_pkg` holds:
  - the FSM state enum;
  - the settings-data field constants (load bit 31, offset [23:0], shift 8);
  - the accumulator width constant (32).
- Sub-module `rx_dc_cal_accum`: one per channel. It does clear, conditional accumulate, and shift-and-saturate to the 24-bit offset.

## Test plan
- I=100, Q=−50 constant, `log2_len`=4 → writes 0x80000000 ×2, then I 0x80FF9C00, Q 0x80003200. `dc_i`=100, `dc_q`=−50. One `done` pulse.
- I ramp 0..15, `log2_len`=4 → `dc_i`=7, I write 0x80FFF900.
- I=−32768, `log2_len`=0 → saturated I write 0x807FFF00.
- `sample_vld` on alternate cycles, `log2_len`=2 → exactly 4 valid samples summed. Cycle T per Timing.
- `abort` mid-ACCUM → `busy` low next cycle, no further `set_stb`, no `done`, `dc_*` unchanged. `start` pulsed while busy has no effect.
- `rst_n` asserted during ACCUM → all outputs 0 immediately. A fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/rx_dc_cal_pkg.sv
// rx_dc_cal_pkg: shared types and constants for the RX frontend DC-offset
// calibration sequencer.
//   - state_t   : sequencer FSM states
//   - ACC_W     : accumulator width
//   - LOAD_BIT / OFF_W / OFF_SHIFT : settings-data word layout
//   - set_word(): packs a 24-bit offset into a settings-bus data word
package rx_dc_cal_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR_I,
    ST_CLR_Q,
    ST_SETTLE,
    ST_ACCUM,
    ST_DIVIDE,
    ST_WR_I,
    ST_WR_Q,
    ST_DONE
  } state_t;

  localparam int ACC_W     = 32;
  localparam int LOAD_BIT  = 31;
  localparam int OFF_W     = 24;
  localparam int OFF_SHIFT = 8;

  // {load, 7'b0, offset[23:0]}
  function automatic logic [31:0] set_word(input logic [OFF_W-1:0] off);
    logic [31:0] w;
    w               = '0;
    w[LOAD_BIT]     = 1'b1;
    w[OFF_W-1:0]    = off;
    return w;
  endfunction

endpackage

// File: rtl/rx_dc_cal_accum.sv
// rx_dc_cal_accum: one calibration channel. Accumulates sign-extended
// samples, and presents the mean (acc >>> log2_len) and the 24-bit
// correction offset (-mean, saturated to 16 bits, shifted left 8).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          zero the accumulator
//   en           add sample this cycle
//   log2_len     averaging length exponent
//   sample       signed input sample
//   mean         signed mean of the accumulated samples
//   offset       negated, saturated mean in settings-word offset format
module rx_dc_cal_accum
  import rx_dc_cal_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [3:0]               log2_len,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] mean,
  output logic [OFF_W-1:0]         offset
);

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  // Negate in one extra bit so -(-32768) is representable before clamping.
  function automatic logic signed [DATA_W-1:0] sat_neg(
    input logic signed [ACC_W-1:0] m
  );
    logic signed [ACC_W:0] n;
    n = -$signed({m[ACC_W-1], m});
    if (n > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (n < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return n[DATA_W-1:0];
  endfunction

  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [ACC_W-1:0]  mean_full;
  logic signed [DATA_W-1:0] neg_sat;

  // Stage p0: accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_p0 <= '0;
    else if (clr) acc_p0 <= '0;
    else if (en)  acc_p0 <= acc_p0 + $signed({{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample});
  end

  // The accumulator is stable outside ACCUM, so the mean and offset are
  // derived combinationally and registered by the sequencer.
  always_comb begin
    mean_full = acc_p0 >>> log2_len;
    mean      = mean_full[DATA_W-1:0];
    neg_sat   = sat_neg(mean_full);
    offset    = {neg_sat, {OFF_SHIFT{1'b0}}};
  end

endmodule

// File: rtl/rx_frontend_dc_cal.sv
// rx_frontend_dc_cal: DC-offset calibration sequencer for rx_frontend.
// On start: clears the I/Q offset registers over the settings bus, waits
// SETTLE_CYC cycles, averages 2^log2_len valid samples per channel, then
// writes the negated mean back as the new offsets.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          begin / cancel calibration (abort wins)
//   log2_len              averaging length exponent, latched at start
//   sample_i/q, sample_vld  frontend output samples and qualifier
//   set_stb/addr/data     settings-bus write (addr/data 0 when idle)
//   busy, done            status; done is a one-cycle completion pulse
//   dc_i, dc_q            last computed means
// Build option: define RX_DC_CAL_Q_EN to calibrate the Q channel too;
// otherwise the Q accumulator, CLR_Q and WR_Q are absent and dc_q is 0.
module rx_frontend_dc_cal
  import rx_dc_cal_pkg::*;
#(
  parameter int unsigned BASE       = 0,
  parameter int unsigned OFF_I      = 0,
  parameter int unsigned OFF_Q      = 1,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         log2_len,
  input  logic signed [15:0] sample_i,
  input  logic signed [15:0] sample_q,
  input  logic               sample_vld,
  output logic               set_stb,
  output logic [7:0]         set_addr,
  output logic [31:0]        set_data,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] dc_i,
  output logic signed [15:0] dc_q
);

`ifdef RX_DC_CAL_Q_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif

  localparam logic [7:0] ADDR_I = 8'(BASE + OFF_I);
  localparam logic [7:0] ADDR_Q = 8'(BASE + OFF_Q);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [3:0]  len_r;
  logic        last_smp;
  logic        acc_clr, acc_en;

  logic signed [15:0] mean_i;
  logic [OFF_W-1:0]   off_i, off_q;

  // Last sample when the count reaches 2^len - 1 (mask of len low ones).
  assign last_smp = (cnt == ~(16'hFFFF << len_r));
  assign acc_clr  = (state_nxt == ST_ACCUM) && (state != ST_ACCUM);
  assign acc_en   = (state == ST_ACCUM) && sample_vld && !abort;

  rx_dc_cal_accum #(.DATA_W(16)) u_acc_i (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .log2_len (len_r),
    .sample   (sample_i),
    .mean     (mean_i),
    .offset   (off_i)
  );

`ifdef RX_DC_CAL_Q_EN
  logic signed [15:0] mean_q;
  rx_dc_cal_accum #(.DATA_W(16)) u_acc_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .log2_len (len_r),
    .sample   (sample_q),
    .mean     (mean_q),
    .offset   (off_q)
  );
`else
  logic unused_q;
  assign unused_q = ^sample_q;
  assign off_q    = '0;
  assign dc_q     = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start && !abort) state_nxt = ST_CLR_I;
      ST_CLR_I:  state_nxt = Q_EN ? ST_CLR_Q : ST_SETTLE;
      ST_CLR_Q:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == 16'(SETTLE_CYC - 1)) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (sample_vld && last_smp) state_nxt = ST_DIVIDE;
      ST_DIVIDE: state_nxt = ST_WR_I;
      ST_WR_I:   state_nxt = Q_EN ? ST_WR_Q : ST_DONE;
      ST_WR_Q:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len_r <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                     cnt <= '0;
      else if (state == ST_SETTLE)                cnt <= cnt + 16'd1;
      else if (state == ST_ACCUM && sample_vld)   cnt <= cnt + 16'd1;
      if (state == ST_IDLE && state_nxt == ST_CLR_I) len_r <= log2_len;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dc_i     <= '0;
`ifdef RX_DC_CAL_Q_EN
      dc_q     <= '0;
`endif
    end else begin
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
      case (state_nxt)
        ST_CLR_I: begin set_stb <= 1'b1; set_addr <= ADDR_I; set_data <= set_word('0);   end
        ST_CLR_Q: begin set_stb <= 1'b1; set_addr <= ADDR_Q; set_data <= set_word('0);   end
        ST_WR_I:  begin set_stb <= 1'b1; set_addr <= ADDR_I; set_data <= set_word(off_i); end
        ST_WR_Q:  begin set_stb <= 1'b1; set_addr <= ADDR_Q; set_data <= set_word(off_q); end
        default: ;
      endcase
      if (state == ST_DIVIDE && !abort) begin
        dc_i <= mean_i;
`ifdef RX_DC_CAL_Q_EN
        dc_q <= mean_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rx_frontend_dc_cal.sv
module tb_rx_frontend_dc_cal;

`ifdef RX_DC_CAL_Q_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif
  localparam int SETTLE = 16;
  localparam int NC     = 200;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [3:0]         log2_len = '0;
  logic signed [15:0] sample_i = '0;
  logic signed [15:0] sample_q = '0;
  logic               sample_vld = 1'b0;
  logic               set_stb;
  logic [7:0]         set_addr;
  logic [31:0]        set_data;
  logic               busy;
  logic               done;
  logic signed [15:0] dc_i;
  logic signed [15:0] dc_q;

  rx_frontend_dc_cal #(
    .BASE(0), .OFF_I(0), .OFF_Q(1), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .log2_len(log2_len), .sample_i(sample_i), .sample_q(sample_q),
    .sample_vld(sample_vld), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .busy(busy), .done(done), .dc_i(dc_i), .dc_q(dc_q)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int si [NC];
  int sq [NC];
  bit sv [NC];
  int dc_i_m = 0;
  int dc_q_m = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Floor division of a signed sum by a positive count.
  function automatic int fdiv(input longint s, input int n);
    if (s >= 0) return int'(s / n);
    return int'(-((-s + n - 1) / n));
  endfunction

  // Settings word carrying the correction for a given mean.
  function automatic longint word_for(input int mean);
    longint neg;
    neg = -mean;
    if (neg > 32767) neg = 32767;
    return 64'h80000000 + ((neg * 256) & 64'hFFFFFF);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return r;
  endfunction

  // mode 0: constants, all valid; 1: I ramp from ACCUM start, all valid;
  // 2: random values, valid on alternate cycles; 3: random values/valid.
  task automatic fill(input int mode, input int ci, input int cq);
    int s;
    s = (Q_EN ? 3 : 2) + SETTLE;
    for (int c = 0; c < NC; c++) begin
      case (mode)
        0: begin si[c] = ci; sq[c] = cq; sv[c] = 1'b1; end
        1: begin si[c] = (c >= s) ? c - s : 1000; sq[c] = cq; sv[c] = 1'b1; end
        2: begin si[c] = rnd16(); sq[c] = rnd16(); sv[c] = c[0]; end
        default: begin si[c] = rnd16(); sq[c] = rnd16(); sv[c] = ($urandom_range(0, 9) < 6); end
      endcase
    end
  endtask

  // One calibration, checked cycle by cycle. abort_at < 0 means no abort.
  task automatic run(input int L, input int abort_at, input bit noise);
    int     n, s, t, cnt, d, last, mi, mq;
    longint sum_i, sum_q;
    bit     e_stb, e_done, e_busy;
    longint e_addr, e_data, e_dci, e_dcq;
    n = 1 << L;
    s = (Q_EN ? 3 : 2) + SETTLE;
    t = -1; cnt = 0; sum_i = 0; sum_q = 0;
    for (int c = s; c < NC - 8 && t < 0; c++) begin
      if (sv[c]) begin
        sum_i += si[c]; sum_q += sq[c]; cnt++;
        if (cnt == n) t = c;
      end
    end
    if (t < 0) begin
      check("sample_window_found", 0, 1);
      return;
    end
    mi   = fdiv(sum_i, n);
    mq   = fdiv(sum_q, n);
    d    = Q_EN ? t + 4 : t + 3;
    last = (abort_at >= 0) ? abort_at : d;
    for (int c = 0; c <= last + 2; c++) begin
      @(posedge clk); #1;
      start      = (c == 0) || (noise && c <= last - 1 && $urandom_range(0, 3) == 0);
      abort      = (c == abort_at);
      log2_len   = (c == 0) ? 4'(L) : 4'($urandom);
      sample_i   = 16'(si[c]);
      sample_q   = 16'(sq[c]);
      sample_vld = sv[c];
      @(negedge clk);
      e_stb = 0; e_addr = 0; e_data = 0;
      if (c <= last) begin
        if (c == 1)              begin e_stb = 1; e_addr = 0; e_data = 64'h80000000; end
        if (Q_EN && c == 2)      begin e_stb = 1; e_addr = 1; e_data = 64'h80000000; end
        if (c == t + 2)          begin e_stb = 1; e_addr = 0; e_data = word_for(mi); end
        if (Q_EN && c == t + 3)  begin e_stb = 1; e_addr = 1; e_data = word_for(mq); end
      end
      e_busy = (c >= 1 && c <= last);
      e_done = (abort_at < 0 && c == d);
      check("busy", busy, e_busy);
      check("set_stb", set_stb, e_stb);
      check("set_addr", set_addr, e_addr);
      check("set_data", set_data, e_data);
      check("done", done, e_done);
      if (c == 0 || c > last) begin
        e_dci = (c > last && abort_at < 0) ? mi : dc_i_m;
        e_dcq = Q_EN ? ((c > last && abort_at < 0) ? mq : dc_q_m) : 0;
        check("dc_i", dc_i, e_dci);
        check("dc_q", dc_q, e_dcq);
      end
    end
    start = 0; abort = 0; sample_vld = 0;
    if (abort_at < 0) begin
      dc_i_m = mi;
      if (Q_EN) dc_q_m = mq;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stb"}, set_stb, 0);
    check({tag, "_addr"}, set_addr, 0);
    check({tag, "_data"}, set_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dc_i"}, dc_i, 0);
    check({tag, "_dc_q"}, dc_q, 0);
  endtask

  initial begin
    int s;
    s = (Q_EN ? 3 : 2) + SETTLE;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);

    // Constant I=100, Q=-50, 16 samples.
    fill(0, 100, -50);
    run(4, -1, 1'b0);
    check("const_dc_i", dc_i, 100);

    // I ramp 0..15 -> mean 7.
    fill(1, 0, 3);
    run(4, -1, 1'b1);
    check("ramp_dc_i", dc_i, 7);

    // Most negative input, single sample: saturated correction.
    fill(0, -32768, 0);
    run(0, -1, 1'b0);
    check("sat_dc_i", dc_i, -32768);

    // Alternate-cycle valid, 4 samples.
    fill(2, 0, 0);
    run(2, -1, 1'b1);

    // Abort mid-ACCUM.
    fill(3, 0, 0);
    run(4, s + 3, 1'b1);

    // Randomised runs.
    for (int k = 0; k < 4; k++) begin
      fill(3, 0, 0);
      run($urandom_range(0, 5), -1, 1'b1);
    end

    // Reset during ACCUM, then a fresh calibration.
    fill(3, 0, 0);
    @(posedge clk); #1;
    start = 1'b1; log2_len = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (s + 2) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    dc_i_m = 0; dc_q_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill(0, -7, 9);
    run(3, -1, 1'b0);
    check("post_reset_dc_i", dc_i, -7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
